arbiter_rr: RTL and testbench

- Parametrised N-channel round-robin arbiter with valid/ready handshakes and an output buffer of configurable depth.
- Optional packet mode holds a grant until a channel's last beat is accepted.
- Reports the source channel of each output beat.
- Sits between multiple producer streams and one consumer, and replaces the fixed two-input ping-pong arbiter in new designs.

---
 rtl/arbiter_pkg.sv | 36 +++
 rtl/arbiter_buffer.sv | 60 ++++++
 rtl/arbiter_rr.sv | 118 +++++++++++
 tb/tb_arbiter_rr.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared types and helpers for the round-robin arbiter.
// Holds the round-robin pick function and source-index sizing.
package arbiter_pkg;

    localparam int MAX_CH = 64;
    localparam int IDX_W  = 6;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic int src_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // First set bit of valid, scanning last+1, last+2, ... modulo n.
    function automatic pick_t rr_pick(
        input logic [MAX_CH-1:0] valid,
        input int                n,
        input int                last
    );
        pick_t            r;
        logic [IDX_W-1:0] c;
        r = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            c = IDX_W'((last + k) % n);
            if (k <= n && !r.found && valid[c]) begin
                r.found = 1'b1;
                r.idx   = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arbiter_buffer.sv
// arbiter_buffer: circular FIFO with push/pop, full/empty and count.
// Ports: i_push/i_data write, i_pop/o_data read head, o_full/o_empty/o_count.
module arbiter_buffer
    import arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (i_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

    assign o_data  = mem[rd_ptr];
    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (o_count == '0);

endmodule

// File: rtl/arbiter_rr.sv
// arbiter_rr: N-channel round-robin arbiter with output buffer and packet lock.
// Ports: i_in_* per-channel streams, o_in_ready grant, o_x_* buffered output.
module arbiter_rr
    import arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 2,
    parameter int PACKET   = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [CHANNELS*WIDTH-1:0]   i_in_data,
    input  logic [CHANNELS-1:0]         i_in_last,
    input  logic [CHANNELS-1:0]         i_in_valid,
    output logic [CHANNELS-1:0]         o_in_ready,
    output logic [WIDTH-1:0]            o_x_data,
    output logic                        o_x_last,
    output logic [$clog2(CHANNELS)-1:0] o_x_source,
    output logic                        o_x_valid,
    input  logic                        i_x_ready
);

    localparam int SW = src_w(CHANNELS);
    localparam int BW = WIDTH + 1 + SW;
    localparam int CW = $clog2(DEPTH + 1);

    logic [SW-1:0]     last_grant;
    logic [SW-1:0]     lock_ch;
    logic [SW-1:0]     grant;
    logic              locked;
    logic              grant_ok;
    logic              space;
    logic              accept;
    logic              pop;
    logic              sel_valid;
    logic              sel_last;
    logic [WIDTH-1:0]  sel_data;
    logic [MAX_CH-1:0] valid_ext;
    pick_t             pick;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              unused_full;
    logic [BW-1:0]     head;

    // A held lock overrides the round-robin scan.
    always_comb begin
        valid_ext = '0;
        valid_ext[CHANNELS-1:0] = i_in_valid;
        pick     = rr_pick(valid_ext, CHANNELS, int'(last_grant));
        grant    = '0;
        grant_ok = 1'b0;
        if (locked) begin
            grant    = lock_ch;
            grant_ok = 1'b1;
        end else if (pick.found) begin
            grant    = pick.idx[SW-1:0];
            grant_ok = 1'b1;
        end
    end

    always_comb begin
        sel_data   = '0;
        sel_last   = 1'b0;
        sel_valid  = 1'b0;
        o_in_ready = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (grant == SW'(n)) begin
                sel_data      = i_in_data[n*WIDTH +: WIDTH];
                sel_last      = i_in_last[n];
                sel_valid     = i_in_valid[n];
                o_in_ready[n] = grant_ok && space && !i_rst;
            end
        end
    end

    // Space comes from the registered count only, never from i_x_ready.
    assign space  = (count < CW'(DEPTH));
    assign accept = grant_ok && space && sel_valid && !i_rst;
    assign pop    = o_x_valid && i_x_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant <= SW'(CHANNELS - 1);
            locked     <= 1'b0;
            lock_ch    <= '0;
        end else if (accept) begin
            last_grant <= grant;
            if (PACKET != 0) begin
                locked  <= !sel_last;
                lock_ch <= grant;
            end
        end
    end

    arbiter_buffer #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (accept),
        .i_data  ({sel_data, sel_last, grant}),
        .i_pop   (pop),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count)
    );

    assign unused_full = full;
    assign o_x_valid   = !empty;
    assign o_x_data    = head[BW-1 -: WIDTH];
    assign o_x_last    = head[SW];
    assign o_x_source  = head[SW-1:0];

endmodule

// File: tb/tb_arbiter_rr.sv
// tb_arbiter_rr: scoreboard bench for arbiter_rr in three configurations.
// A: DEPTH=2 PACKET=0, B: DEPTH=2 PACKET=1, C: DEPTH=1 PACKET=0.
module tb_arbiter_rr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  src;
        logic        last;
        logic [31:0] data;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];

    logic [127:0] a_din, b_din, c_din;
    logic [3:0]   a_last, b_last, c_last;
    logic [3:0]   a_val, b_val, c_val;
    logic [3:0]   a_rdy, b_rdy, c_rdy;
    logic [31:0]  a_xd, b_xd, c_xd;
    logic         a_xl, b_xl, c_xl;
    logic [1:0]   a_xs, b_xs, c_xs;
    logic         a_xv, b_xv, c_xv;
    logic         a_xr, b_xr, c_xr;

    arbiter_rr #(.WIDTH(32), .CHANNELS(4), .DEPTH(2), .PACKET(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_in_data(a_din), .i_in_last(a_last),
        .i_in_valid(a_val), .o_in_ready(a_rdy), .o_x_data(a_xd),
        .o_x_last(a_xl), .o_x_source(a_xs), .o_x_valid(a_xv),
        .i_x_ready(a_xr)
    );

    arbiter_rr #(.WIDTH(32), .CHANNELS(4), .DEPTH(2), .PACKET(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_in_data(b_din), .i_in_last(b_last),
        .i_in_valid(b_val), .o_in_ready(b_rdy), .o_x_data(b_xd),
        .o_x_last(b_xl), .o_x_source(b_xs), .o_x_valid(b_xv),
        .i_x_ready(b_xr)
    );

    arbiter_rr #(.WIDTH(32), .CHANNELS(4), .DEPTH(1), .PACKET(0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_in_data(c_din), .i_in_last(c_last),
        .i_in_valid(c_val), .o_in_ready(c_rdy), .o_x_data(c_xd),
        .o_x_last(c_xl), .o_x_source(c_xs), .o_x_valid(c_xv),
        .i_x_ready(c_xr)
    );

    function automatic logic [31:0] dv(input int ch);
        return 32'hA000_0000 + 32'(ch);
    endfunction

    function automatic logic [127:0] bus_const();
        return {dv(3), dv(2), dv(1), dv(0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic beat_cmp(input string nm, input bit have,
                            input beat_t e, input beat_t g);
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL %s: got beat %0h, expected none", nm, g);
        end else begin
            chk(nm, 64'(g), 64'(e));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && a_xv && a_xr) begin
            beat_t e;
            bit    have;
            have = qa.size() > 0;
            e    = '0;
            if (have) e = qa.pop_front();
            beat_cmp("a_beat", have, e, {a_xs, a_xl, a_xd});
        end
    end

    always @(negedge clk) begin
        if (!rst && b_xv && b_xr) begin
            beat_t e;
            bit    have;
            have = qb.size() > 0;
            e    = '0;
            if (have) e = qb.pop_front();
            beat_cmp("b_beat", have, e, {b_xs, b_xl, b_xd});
        end
    end

    always @(negedge clk) begin
        if (!rst && c_xv && c_xr) begin
            beat_t e;
            bit    have;
            have = qc.size() > 0;
            e    = '0;
            if (have) e = qc.pop_front();
            beat_cmp("c_beat", have, e, {c_xs, c_xl, c_xd});
        end
    end

    task automatic idle();
        a_val = '0; b_val = '0; c_val = '0;
        a_last = '0; b_last = '0; c_last = '0;
        a_xr = 1'b1; b_xr = 1'b1; c_xr = 1'b1;
        a_din = bus_const(); b_din = bus_const(); c_din = bus_const();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        a_val = 4'hF; b_val = 4'hF; c_val = 4'hF;
        #2;
        chk("rst_a_ready", 64'(a_rdy), 64'h0);
        chk("rst_b_ready", 64'(b_rdy), 64'h0);
        chk("rst_c_ready", 64'(c_rdy), 64'h0);
        chk("rst_a_out", 64'({a_xv, a_xl, a_xs, a_xd}), 64'h0);
        chk("rst_b_out", 64'({b_xv, b_xl, b_xs, b_xd}), 64'h0);
        chk("rst_c_out", 64'({c_xv, c_xl, c_xs, c_xd}), 64'h0);

        // Fairness: all valid, grants cycle 0,1,2,3,0,1.
        do_reset();
        a_val = 4'hF;
        for (int i = 0; i < 6; i++) begin
            qa.push_back({2'(i % 4), 1'b0, dv(i % 4)});
            @(negedge clk);
            chk("t1_valid", 64'(a_xv), (i == 0) ? 64'h0 : 64'h1);
            chk("t1_ready", 64'(a_rdy), 64'h1 << (i % 4));
            next_cycle();
        end
        a_val = '0;
        @(negedge clk);
        chk("t1_tail_valid", 64'(a_xv), 64'h1);
        drain();

        // Only channels 1 and 3 valid.
        do_reset();
        a_val = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            qa.push_back({(i % 2 == 0) ? 2'd1 : 2'd3, 1'b0,
                          dv((i % 2 == 0) ? 1 : 3)});
            @(negedge clk);
            chk("t2_no_ready02", 64'(a_rdy & 4'b0101), 64'h0);
            chk("t2_ready", 64'(a_rdy), (i % 2 == 0) ? 64'h2 : 64'h8);
            next_cycle();
        end
        drain();

        // Backpressure with DEPTH=2: fill, hold, release.
        do_reset();
        a_xr = 1'b0;
        a_val = 4'b0101;
        qa.push_back({2'd0, 1'b0, dv(0)});
        @(negedge clk);
        chk("t3_ready0", 64'(a_rdy), 64'h1);
        next_cycle();
        qa.push_back({2'd2, 1'b0, dv(2)});
        @(negedge clk);
        chk("t3_ready2", 64'(a_rdy), 64'h4);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_full_ready", 64'(a_rdy), 64'h0);
            chk("t3_hold", 64'({a_xv, a_xs, a_xd}),
                64'({1'b1, 2'd0, dv(0)}));
            next_cycle();
        end
        a_xr = 1'b1;
        @(negedge clk);
        chk("t3_still_full", 64'(a_rdy), 64'h0);
        next_cycle();
        qa.push_back({2'd0, 1'b0, dv(0)});
        @(negedge clk);
        chk("t3_resume0", 64'(a_rdy), 64'h1);
        next_cycle();
        drain();

        // Packet lock on channel 1 while channel 2 waits.
        do_reset();
        b_val = 4'b0110;
        b_din[32 +: 32] = 32'h1101;
        b_din[64 +: 32] = 32'h2200;
        qb.push_back({2'd1, 1'b0, 32'h1101});
        @(negedge clk);
        chk("t4_ready_b1", 64'(b_rdy), 64'h2);
        next_cycle();
        b_din[32 +: 32] = 32'h1102;
        qb.push_back({2'd1, 1'b0, 32'h1102});
        @(negedge clk);
        chk("t4_ready_b2", 64'(b_rdy), 64'h2);
        next_cycle();
        b_val = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_gap_no_ch2", 64'(b_rdy & 4'b0100), 64'h0);
            next_cycle();
        end
        b_val = 4'b0110;
        b_last = 4'b0010;
        b_din[32 +: 32] = 32'h1103;
        qb.push_back({2'd1, 1'b1, 32'h1103});
        @(negedge clk);
        chk("t4_ready_b3", 64'(b_rdy), 64'h2);
        next_cycle();
        b_val = 4'b0100;
        b_last = 4'b0100;
        qb.push_back({2'd2, 1'b1, 32'h2200});
        @(negedge clk);
        chk("t4_ready_ch2", 64'(b_rdy), 64'h4);
        next_cycle();
        drain();

        // DEPTH=1: one beat every two cycles.
        do_reset();
        c_val = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            if (k % 2 == 1) begin
                qc.push_back({2'((k - 1) / 2), 1'b0, dv((k - 1) / 2)});
            end
            @(negedge clk);
            chk("t5_valid", 64'(c_xv), (k % 2 == 0) ? 64'h1 : 64'h0);
            chk("t5_ready", 64'(c_rdy),
                (k % 2 == 1) ? (64'h1 << ((k - 1) / 2)) : 64'h0);
            next_cycle();
        end
        drain();

        // Async reset with a locked, buffered beat.
        do_reset();
        b_xr = 1'b0;
        b_val = 4'b0100;
        b_din[64 +: 32] = 32'h2201;
        @(negedge clk);
        chk("t6_ready2", 64'(b_rdy), 64'h4);
        next_cycle();
        chk("t6_buffered", 64'(b_xv), 64'h1);
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 64'(b_xv), 64'h0);
        chk("t6_async_ready", 64'(b_rdy), 64'h0);
        next_cycle();
        rst = 1'b0;
        b_xr = 1'b1;
        b_val = 4'b0101;
        qb.push_back({2'd0, 1'b0, dv(0)});
        @(negedge clk);
        chk("t6_ch0_first", 64'(b_rdy), 64'h1);
        next_cycle();
        drain();

        chk("end_qa_empty", 64'(qa.size()), 64'h0);
        chk("end_qb_empty", 64'(qb.size()), 64'h0);
        chk("end_qc_empty", 64'(qc.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
